// File: rtl/rca_accumulator.sv
// Registered accumulate stage around a ripple-carry adder, with z/n/c/v flags,
// a sticky overflow flag and a single-entry valid/ready output stage.

module ripple_carry_adder #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic                 add_sub_b,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 carry_out,
  output logic                 overflow
);

  logic [BUS_WIDTH:0]   carry;
  logic [BUS_WIDTH-1:0] in2_eff;

  // Subtraction is in1 + ~in2 + 1, so the carry-in doubles as the +1.
  assign in2_eff  = in2 ^ {BUS_WIDTH{add_sub_b}};
  assign carry[0] = add_sub_b;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_fa
    assign out[i]       = in1[i] ^ in2_eff[i] ^ carry[i];
    assign carry[i+1]   = (in1[i] & in2_eff[i]) | (carry[i] & (in1[i] ^ in2_eff[i]));
  end

  assign carry_out = carry[BUS_WIDTH];
  assign overflow  = carry[BUS_WIDTH] ^ carry[BUS_WIDTH-1];

endmodule

module rca_accumulator #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic                 sign,
  input  logic [BUS_WIDTH-1:0] operand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] acc,
  output logic                 z,
  output logic                 n,
  output logic                 c,
  output logic                 v,
  output logic                 v_sticky
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic                 accept;
  logic [BUS_WIDTH-1:0] sum;
  logic                 sum_carry;
  logic                 sum_ovf;
  logic                 ovf_flag;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ovf_flag = sign && sum_ovf;

  ripple_carry_adder #(.BUS_WIDTH(BUS_WIDTH)) u_adder (
    .in1       (acc),
    .in2       (operand),
    .add_sub_b (op == OP_SUB),
    .out       (sum),
    .carry_out (sum_carry),
    .overflow  (sum_ovf)
  );

  // Accumulator and flags only move on an accepted command; consuming a
  // result never disturbs them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      z         <= 1'b1;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      v_sticky  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        case (op)
          OP_LOAD: begin
            acc      <= operand;
            z        <= (operand == '0);
            n        <= operand[BUS_WIDTH-1];
            c        <= 1'b0;
            v        <= 1'b0;
            v_sticky <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc      <= sum;
            z        <= (sum == '0);
            n        <= sum[BUS_WIDTH-1];
            c        <= sum_carry;
            v        <= ovf_flag;
            v_sticky <= v_sticky | ovf_flag;
          end
          OP_CLEAR: begin
            acc      <= '0;
            z        <= 1'b1;
            n        <= 1'b0;
            c        <= 1'b0;
            v        <= 1'b0;
            v_sticky <= 1'b0;
          end
          default: begin
            acc <= acc;
          end
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Scoreboard bench for rca_accumulator: an independent reference model pushes
// expected results on accept and they are popped when the DUT presents them.

module tb_rca_accumulator;

  localparam int W = 8;
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         vs;
  } result_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         sign;
  logic [W-1:0] operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] acc;
  logic         z, n, c, v, v_sticky;

  int n_vectors = 0;
  int n_miscompares = 0;

  result_t model;
  logic    model_ov;
  result_t sb_q[$];

  rca_accumulator #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sign      (sign),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v),
    .v_sticky  (v_sticky)
  );

  always #5 clk = ~clk;

  function automatic result_t model_next(input result_t cur, input logic [1:0] o,
                                         input logic s, input logic [W-1:0] d);
    result_t r;
    logic [W:0] wide;
    r = cur;
    case (o)
      LOAD: begin
        r.acc = d; r.z = (d == 0); r.n = d[W-1]; r.c = 0; r.v = 0; r.vs = 0;
      end
      ADD: begin
        wide  = {1'b0, cur.acc} + {1'b0, d};
        r.acc = wide[W-1:0];
        r.c   = wide[W];
        r.v   = s && (cur.acc[W-1] == d[W-1]) && (r.acc[W-1] != cur.acc[W-1]);
        r.z   = (r.acc == 0); r.n = r.acc[W-1]; r.vs = cur.vs | r.v;
      end
      SUB: begin
        r.acc = cur.acc - d;
        r.c   = (cur.acc >= d);
        r.v   = s && (cur.acc[W-1] != d[W-1]) && (r.acc[W-1] != cur.acc[W-1]);
        r.z   = (r.acc == 0); r.n = r.acc[W-1]; r.vs = cur.vs | r.v;
      end
      default: begin
        r.acc = 0; r.z = 1; r.n = 0; r.c = 0; r.v = 0; r.vs = 0;
      end
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, push expectation on accept, check #1 after posedge.
  task automatic drive_cycle(input logic r, input logic iv, input logic [1:0] o,
                             input logic s, input logic [W-1:0] d, input logic ordy);
    logic    exp_ready;
    logic    accepted;
    result_t got;
    result_t exp;
    @(negedge clk);
    rst = r; in_valid = iv; op = o; sign = s; operand = d; out_ready = ordy;
    #1;
    exp_ready = !model_ov || ordy;
    if (!r) begin
      n_vectors++;
      if (in_ready !== exp_ready) begin
        n_miscompares++;
        $display("[TB] FAIL in_ready: got %b expected %b", in_ready, exp_ready);
      end
    end
    accepted = iv && exp_ready && !r;
    if (accepted) sb_q.push_back(model_next(model, o, s, d));
    @(posedge clk);
    #1;
    if (r) begin
      model = '{acc: 0, z: 1, n: 0, c: 0, v: 0, vs: 0};
      model_ov = 0;
    end else if (accepted) begin
      model_ov = 1;
    end else if (ordy) begin
      model_ov = 0;
    end
    n_vectors++;
    if (out_valid !== model_ov) begin
      n_miscompares++;
      $display("[TB] FAIL out_valid: got %b expected %b", out_valid, model_ov);
    end
    got = '{acc: acc, z: z, n: n, c: c, v: v, vs: v_sticky};
    if (accepted) begin
      exp = sb_q.pop_front();
      model = exp;
    end else begin
      exp = model;
    end
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL result: got acc=%0d z%b n%b c%b v%b vs%b expected acc=%0d z%b n%b c%b v%b vs%b",
               got.acc, got.z, got.n, got.c, got.v, got.vs,
               exp.acc, exp.z, exp.n, exp.c, exp.v, exp.vs);
    end
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, ADD, 0, 8'd5, 0);
    drive_cycle(1, 1, ADD, 0, 8'd5, 0);
    drive_cycle(1, 1, ADD, 0, 8'd5, 0);
    n_vectors++;
    if (acc !== 8'd0 || z !== 1'b1 || out_valid !== 1'b0 || v_sticky !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_state: got acc=%0d z=%b ov=%b vs=%b expected 0 1 0 0",
               acc, z, out_valid, v_sticky);
    end
    drive_cycle(0, 0, ADD, 0, 8'd0, 1);
  endtask

  task automatic test_load_add();
    drive_cycle(0, 1, LOAD, 0, 8'd12, 1);
    n_vectors++;
    if (acc !== 8'd12) begin
      n_miscompares++;
      $display("[TB] FAIL load12: got %0d expected 12", acc);
    end
    drive_cycle(0, 1, ADD, 0, 8'd24, 1);
    n_vectors++;
    if (acc !== 8'd36 || {z, n, c, v} !== 4'b0000 || out_valid !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL add24: got acc=%0d znc v=%b%b%b%b ov=%b expected 36 0000 1",
               acc, z, n, c, v, out_valid);
    end
    drive_cycle(0, 0, ADD, 0, 8'd0, 1);
  endtask

  task automatic test_carry_borrow();
    drive_cycle(0, 1, LOAD, 0, 8'd110, 1);
    drive_cycle(0, 1, SUB, 0, 8'd24, 1);
    n_vectors++;
    if (acc !== 8'd86 || c !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL sub24: got acc=%0d c=%b expected 86 1", acc, c);
    end
    drive_cycle(0, 1, LOAD, 0, 8'd110, 1);
    drive_cycle(0, 1, ADD, 0, 8'd220, 1);
    n_vectors++;
    if (acc !== 8'd74 || c !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL add220: got acc=%0d c=%b expected 74 1", acc, c);
    end
    drive_cycle(0, 1, LOAD, 0, 8'd110, 1);
    drive_cycle(0, 1, SUB, 0, 8'd220, 1);
    n_vectors++;
    if (acc !== 8'd146 || c !== 1'b0 || n !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL sub220: got acc=%0d c=%b n=%b expected 146 0 1", acc, c, n);
    end
  endtask

  task automatic test_signed_overflow();
    drive_cycle(0, 1, LOAD, 1, 8'd100, 1);
    drive_cycle(0, 1, ADD, 1, 8'd100, 1);
    n_vectors++;
    if (acc !== 8'hC8 || v !== 1'b1 || n !== 1'b1 || v_sticky !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL sovf: got acc=%0d v=%b n=%b vs=%b expected 200 1 1 1", acc, v, n, v_sticky);
    end
    drive_cycle(0, 1, ADD, 1, 8'd0, 1);
    n_vectors++;
    if (v !== 1'b0 || v_sticky !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL sticky_hold: got v=%b vs=%b expected 0 1", v, v_sticky);
    end
    drive_cycle(0, 1, SUB, 1, 8'd200, 1);
    n_vectors++;
    if (acc !== 8'd0 || z !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL sub_to_zero: got acc=%0d z=%b expected 0 1", acc, z);
    end
    drive_cycle(0, 1, CLEAR, 1, 8'd77, 1);
    n_vectors++;
    if (v_sticky !== 1'b0 || z !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL clear: got vs=%b z=%b expected 0 1", v_sticky, z);
    end
    drive_cycle(0, 0, ADD, 0, 8'd0, 1);
  endtask

  task automatic test_backpressure();
    drive_cycle(0, 1, LOAD, 0, 8'd7, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, ADD, 0, 8'd3, 0);
      n_vectors++;
      if (acc !== 8'd7 || in_ready !== 1'b0) begin
        n_miscompares++;
        $display("[TB] FAIL stall%0d: got acc=%0d in_ready=%b expected 7 0", i, acc, in_ready);
      end
    end
    drive_cycle(0, 1, ADD, 0, 8'd3, 1);
    n_vectors++;
    if (acc !== 8'd10 || out_valid !== 1'b1) begin
      n_miscompares++;
      $display("[TB] FAIL release: got acc=%0d ov=%b expected 10 1", acc, out_valid);
    end
    drive_cycle(0, 0, ADD, 0, 8'd3, 1);
    n_vectors++;
    if (out_valid !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL drain: got ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    drive_cycle(0, 1, LOAD, 0, 8'd50, 1);
    drive_cycle(1, 1, ADD, 0, 8'd1, 1);
    n_vectors++;
    if (acc !== 8'd0 || z !== 1'b1 || out_valid !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL mid_reset: got acc=%0d z=%b ov=%b expected 0 1 0", acc, z, out_valid);
    end
    drive_cycle(0, 0, ADD, 0, 8'd0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) != 0));
    end
    drive_cycle(0, 0, ADD, 0, 8'd0, 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; op = LOAD; sign = 0; operand = 0; out_ready = 0;
    model = '{acc: 0, z: 1, n: 0, c: 0, v: 0, vs: 0};
    model_ov = 0;
    test_reset();
    test_load_add();
    test_carry_borrow();
    test_signed_overflow();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
